// File: rtl/fpu_norm_sequencer.sv
// rtl/fpu_norm_sequencer.sv - multi-cycle normalizer for raw FPU adder results
module fpu_norm_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [24:0] mantissa,
   input  logic [7:0]  exponent,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [22:0] normalized_mantissa,
   output logic [7:0]  normalized_exponent,
   output logic        overflow_underflow_flag,
   output logic        zero_flag,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   state_t      state, state_next;
   logic [24:0] m, m_next;
   logic [7:0]  e, e_next;
   logic        ovf, ovf_next;
   logic        zf, zf_next;

   // State register; reset discards any in-flight operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Working mantissa, exponent and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m   <= '0;
         e   <= '0;
         ovf <= 1'b0;
         zf  <= 1'b0;
      end else begin
         m   <= m_next;
         e   <= e_next;
         ovf <= ovf_next;
         zf  <= zf_next;
      end
   end

   // Next state and working values: one normalization rule per NORM cycle,
   // checked in priority order so exponent arithmetic never wraps
   always_comb begin
      state_next = state;
      m_next     = m;
      e_next     = e;
      ovf_next   = ovf;
      zf_next    = zf;
      case (state)
         IDLE: begin
            if (in_valid) begin
               m_next     = mantissa;
               e_next     = exponent;
               ovf_next   = 1'b0;
               zf_next    = 1'b0;
               state_next = NORM;
            end
         end
         NORM: begin
            state_next = DONE;
            if (m == 25'd0) begin
               zf_next = 1'b1;
               e_next  = 8'd0;
               m_next  = 25'd0;
            end else if (e == 8'd255) begin
               ovf_next = 1'b1;
               m_next   = 25'd0;
            end else if (m[24] && (e == 8'd254)) begin
               ovf_next = 1'b1;
               e_next   = 8'd255;
               m_next   = 25'd0;
            end else if (m[24]) begin
               m_next = {1'b0, m[24:1]};
               e_next = e + 8'd1;
            end else if (m[23]) begin
               m_next = m;
            end else if (e <= 8'd1) begin
               ovf_next = 1'b1;
               e_next   = 8'd0;
            end else begin
               m_next     = {m[23:0], 1'b0};
               e_next     = e - 8'd1;
               state_next = NORM;
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign in_ready                = (state == IDLE);
   assign out_valid               = (state == DONE);
   assign busy                    = (state == NORM) || (state == DONE);
   assign normalized_mantissa     = m[22:0];
   assign normalized_exponent     = e;
   assign overflow_underflow_flag = ovf;
   assign zero_flag               = zf;

endmodule

// File: tb/tb_fpu_norm_sequencer.sv
// tb/tb_fpu_norm_sequencer.sv - self-checking bench for fpu_norm_sequencer
module tb_fpu_norm_sequencer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] mantissa;
   logic [7:0]  exponent;
   logic        out_valid;
   logic        out_ready;
   logic [22:0] normalized_mantissa;
   logic [7:0]  normalized_exponent;
   logic        overflow_underflow_flag;
   logic        zero_flag;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic        exp_on = 1'b0;
   logic [22:0] exp_f;
   logic [7:0]  exp_x;
   logic        exp_ov;
   logic        exp_z;

   fpu_norm_sequencer dut (
      .clk                     (clk),
      .rst                     (rst),
      .in_valid                (in_valid),
      .in_ready                (in_ready),
      .mantissa                (mantissa),
      .exponent                (exponent),
      .out_valid               (out_valid),
      .out_ready               (out_ready),
      .normalized_mantissa     (normalized_mantissa),
      .normalized_exponent     (normalized_exponent),
      .overflow_underflow_flag (overflow_underflow_flag),
      .zero_flag               (zero_flag),
      .busy                    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference result from the normalization rules, using a leading-one
   // position and a closed-form shift count rather than stepping cycles.
   function automatic void model(input logic [24:0] m, input logic [7:0] e,
                                 output logic [22:0] f, output logic [7:0] x,
                                 output logic ov, output logic z, output int sh);
      logic [24:0] t;
      int msb;
      int need;
      sh = 0; ov = 1'b0; z = 1'b0; f = '0; x = '0;
      if (m == 25'd0) begin
         z = 1'b1;
      end else if (e == 8'd255) begin
         x = 8'd255; ov = 1'b1;
      end else if (m[24]) begin
         if (e == 8'd254) begin
            x = 8'd255; ov = 1'b1;
         end else begin
            t = m >> 1;
            f = t[22:0];
            x = e + 8'd1;
         end
      end else begin
         msb = 0;
         for (int i = 0; i < 24; i++) if (m[i]) msb = i;
         need = 23 - msb;
         if (int'(e) > need) begin
            sh = need;
            t  = m << need;
            f  = t[22:0];
            x  = 8'(int'(e) - need);
         end else begin
            sh = (e == 8'd0) ? 0 : int'(e) - 1;
            t  = m << sh;
            f  = t[22:0];
            x  = 8'd0;
            ov = 1'b1;
         end
      end
   endfunction

   // Every cycle a result is presented, it must match the reference
   always @(negedge clk) begin
      if (exp_on && out_valid) begin
         check("out_fraction", 32'(normalized_mantissa), 32'(exp_f));
         check("out_exponent", 32'(normalized_exponent), 32'(exp_x));
         check("out_ovf_flag", 32'(overflow_underflow_flag), 32'(exp_ov));
         check("out_zero_flag", 32'(zero_flag), 32'(exp_z));
         check("out_busy", 32'(busy), 32'd1);
         check("out_in_ready", 32'(in_ready), 32'd0);
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_fraction"}, 32'(normalized_mantissa), 32'd0);
      check({tag, "_exponent"}, 32'(normalized_exponent), 32'd0);
      check({tag, "_ovf"}, 32'(overflow_underflow_flag), 32'd0);
      check({tag, "_zero"}, 32'(zero_flag), 32'd0);
   endtask

   // Called at a negedge with the block idle; returns at a negedge, idle again
   task automatic run_op(input logic [24:0] m, input logic [7:0] e, input int hold, input string name);
      int sh;
      int cyc;
      model(m, e, exp_f, exp_x, exp_ov, exp_z, sh);
      check({name, "_in_ready_before"}, 32'(in_ready), 32'd1);
      mantissa = m;
      exponent = e;
      in_valid = 1'b1;
      exp_on   = 1'b1;
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      // junk on the inputs while busy, plus an early out_ready: both must be ignored
      mantissa  = 25'h1ABCDEF;
      exponent  = 8'hC3;
      out_ready = 1'b1;
      while (!out_valid && cyc < 60) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({name, "_latency"}, 32'(cyc), 32'(2 + sh));
      if (!out_valid) return;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_valid_fall"}, 32'(out_valid), 32'd0);
      check({name, "_ready_back"}, 32'(in_ready), 32'd1);
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
      check({name, "_held_fraction"}, 32'(normalized_mantissa), 32'(exp_f));
      check({name, "_held_exponent"}, 32'(normalized_exponent), 32'(exp_x));
      exp_on = 1'b0;
   endtask

   initial begin
      logic [22:0] pf;
      logic [7:0]  px;
      logic        pov;
      logic        pz;
      int          psh;

      // Model pinned against hand-worked results
      model(25'h0800000, 8'd5, pf, px, pov, pz, psh);
      check("pin_norm_exp", 32'(px), 32'd5);
      check("pin_norm_sh", 32'(psh), 32'd0);
      model(25'h0000001, 8'd100, pf, px, pov, pz, psh);
      check("pin_lsb_exp", 32'(px), 32'd77);
      check("pin_lsb_sh", 32'(psh), 32'd23);
      model(25'h1000000, 8'd254, pf, px, pov, pz, psh);
      check("pin_carry_ovf", 32'({pov, px}), 32'h1FF);
      model(25'h1000000, 8'd10, pf, px, pov, pz, psh);
      check("pin_carry_exp", 32'({pov, px}), 32'd11);
      model(25'h0000010, 8'd3, pf, px, pov, pz, psh);
      check("pin_denorm_frac", 32'(pf), 32'h40);
      check("pin_denorm_exp", 32'({pov, px}), 32'h100);
      model(25'h0000000, 8'd77, pf, px, pov, pz, psh);
      check("pin_zero", 32'({pz, px}), 32'h100);
      model(25'h0400000, 8'd9, pf, px, pov, pz, psh);
      check("pin_one_shift", 32'({psh[7:0], px}), 32'h0108);

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      mantissa  = '0;
      exponent  = '0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      run_op(25'h0800000, 8'd5,   0, "already_norm");
      run_op(25'h0000001, 8'd100, 0, "lsb_only");
      run_op(25'h1000000, 8'd254, 0, "carry_ovf");
      run_op(25'h1000000, 8'd10,  0, "carry");
      run_op(25'h0000010, 8'd3,   0, "denorm");
      run_op(25'h0000000, 8'd77,  5, "zero_hold");
      run_op(25'h1FFFFFF, 8'd200, 1, "carry_full");
      run_op(25'h0000123, 8'd255, 0, "exp_max");
      run_op(25'h0000001, 8'd0,   0, "exp_zero");
      run_op(25'h0400000, 8'd1,   0, "exp_one");
      run_op(25'h0000001, 8'd24,  0, "just_fits");
      run_op(25'h0000001, 8'd23,  0, "just_short");

      // Asynchronous reset in the middle of a long normalization
      mantissa = 25'h0000001;
      exponent = 8'd100;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("mid_norm_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1 check_reset_values("async_rst");
      @(negedge clk);
      rst = 1'b0;
      run_op(25'h0400000, 8'd9, 0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
